// File: rtl/btn_event_detect.sv
// Turns the debounced button level into one-cycle press/release/short/long/repeat events.
// Optional auto-repeat while in long-hold is built when BTN_AUTO_REPEAT_EN is defined.
module btn_event_detect #(
    parameter int unsigned LONG_CYC   = 100_000_000,
    parameter int unsigned REPEAT_CYC = 20_000_000,
    parameter int unsigned CNT_W      = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    input  logic       enable,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_press,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] event_cnt
);

    localparam int unsigned EVT_W = 8;

    // Reject configurations where the thresholds cannot be reached by the counters.
    if (LONG_CYC < 2 || REPEAT_CYC < 1 || (64'(LONG_CYC) >> CNT_W) != 64'd0
        || (64'(REPEAT_CYC) >> CNT_W) != 64'd0) begin : g_cfg_err
        $error("btn_event_detect: illegal LONG_CYC/REPEAT_CYC/CNT_W combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               btn_prev_q;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [EVT_W-1:0]   event_cnt_q, event_cnt_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               short_q, short_d;
    logic               long_q, long_d;
    logic               held_q, held_d;
`ifdef BTN_AUTO_REPEAT_EN
    logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d, rep_cnt_nxt;
    logic               repeat_q, repeat_d;
`endif

    // Next-state and event decode; release always takes priority over hold thresholds.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        event_cnt_d = event_cnt_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        short_d     = 1'b0;
        long_d      = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        repeat_d    = 1'b0;
        rep_cnt_nxt = (rep_cnt_q == CNT_W'(REPEAT_CYC)) ? CNT_W'(1) : rep_cnt_q + CNT_W'(1);
`endif

        if (!enable) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
`ifdef BTN_AUTO_REPEAT_EN
            rep_cnt_d  = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_in && !btn_prev_q) begin
                        press_d    = 1'b1;
                        hold_cnt_d = CNT_W'(1);
                        state_d    = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (!btn_in) begin
                        release_d   = 1'b1;
                        short_d     = 1'b1;
                        event_cnt_d = event_cnt_q + EVT_W'(1);
                        hold_cnt_d  = '0;
                        state_d     = ST_IDLE;
                    end else if (hold_cnt_q == CNT_W'(LONG_CYC)) begin
                        long_d      = 1'b1;
                        event_cnt_d = event_cnt_q + EVT_W'(1);
`ifdef BTN_AUTO_REPEAT_EN
                        rep_cnt_d   = '0;
`endif
                        state_d     = ST_LONG_HELD;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end
                ST_LONG_HELD: begin
                    if (!btn_in) begin
                        release_d  = 1'b1;
                        hold_cnt_d = '0;
`ifdef BTN_AUTO_REPEAT_EN
                        rep_cnt_d  = '0;
`endif
                        state_d    = ST_IDLE;
                    end else begin
`ifdef BTN_AUTO_REPEAT_EN
                        rep_cnt_d = rep_cnt_nxt;
                        repeat_d  = (rep_cnt_nxt == CNT_W'(REPEAT_CYC));
`endif
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end
            endcase
        end

        held_d = (state_d != ST_IDLE);
    end

    // State and output registers; btn_prev tracks the input even while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            btn_prev_q  <= 1'b0;
            hold_cnt_q  <= '0;
            event_cnt_q <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            held_q      <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rep_cnt_q   <= '0;
            repeat_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            btn_prev_q  <= btn_in;
            hold_cnt_q  <= hold_cnt_d;
            event_cnt_q <= event_cnt_d;
            press_q     <= press_d;
            release_q   <= release_d;
            short_q     <= short_d;
            long_q      <= long_d;
            held_q      <= held_d;
`ifdef BTN_AUTO_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            repeat_q    <= repeat_d;
`endif
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_press   = short_q;
    assign long_press    = long_q;
    assign held          = held_q;
    assign event_cnt     = event_cnt_q;
`ifdef BTN_AUTO_REPEAT_EN
    assign repeat_pulse  = repeat_q;
`else
    assign repeat_pulse  = 1'b0;
`endif

endmodule
